// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port 160x120 RGB332 framebuffer RAM between
// the VGA pixel fetch (always wins), a pixel-writer client and a full-frame
// clear sequencer. Video reads land on pix_data two cycles after the slot.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no clear outstanding; writer served in non-video cycles
// PEND   | clear requested, colour latched, waiting for end of frame
// CLEAR  | writing latched colour to every address, one per free cycle
module vga_fb_arbiter #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              display,
    input  logic              eof,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_x,
    input  logic [6:0]        wr_y,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_color,
    output logic              busy,
    output logic              clear_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    localparam logic [7:0]        FB_W_L     = 8'(FB_W);
    localparam logic [6:0]        FB_H_L     = 7'(FB_H);
    localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(FB_W * FB_H - 1);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   clear_addr;
    logic [DATA_W-1:0]   color_q;
    logic                rd_d1;
    logic                disp_d1, disp_d2;
    logic [DATA_W-1:0]   pix_q;

    logic                vslot;
    logic                clear_wr;
    logic                wr_in_range;
    logic [7:0]          vid_x;
    logic [7:0]          vid_y;
    logic [ADDR_W-1:0]   vid_addr;
    logic [ADDR_W-1:0]   wr_addr;

    // Low vcount bits only select the screen row inside a 4x4 block.
    logic unused_vbits;
    assign unused_vbits = &{1'b0, vcount[1:0]};

    assign vslot = display && (hcount[1:0] == 2'b00);
    assign vid_x = hcount[9:2];
    assign vid_y = vcount[9:2];

    // Row stride 160 = 128 + 32, built from shifts instead of a multiplier.
    assign vid_addr = ADDR_W'({vid_y, 7'b0}) + ADDR_W'({vid_y, 5'b0}) + ADDR_W'(vid_x);
    assign wr_addr  = ADDR_W'({wr_y, 7'b0}) + ADDR_W'({wr_y, 5'b0}) + ADDR_W'(wr_x);
    assign wr_in_range = (wr_x < FB_W_L) && (wr_y < FB_H_L);

    assign busy      = (state != S_IDLE);
    assign pix_valid = disp_d2;
    assign pix_data  = disp_d2 ? pix_q : '0;

    // State register.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; clear_req is only looked at in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (clear_req) state_nx = S_PEND;
            S_PEND:  if (eof) state_nx = S_CLEAR;
            S_CLEAR: if (clear_wr && (clear_addr == CLEAR_LAST)) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // RAM port mux: video slot, then clear write, then writer.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        clear_wr  = (state == S_CLEAR) && !vslot;
        wr_ready  = !vslot && (state != S_CLEAR);
        if (vslot) begin
            mem_en   = 1'b1;
            mem_addr = vid_addr;
        end else if (clear_wr) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clear_addr;
            mem_wdata = color_q;
        end else if (wr_valid && wr_ready && wr_in_range) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end
    end

    // Clear bookkeeping and the two-stage video read pipeline.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            clear_addr <= '0;
            color_q    <= '0;
            clear_done <= 1'b0;
            rd_d1      <= 1'b0;
            disp_d1    <= 1'b0;
            disp_d2    <= 1'b0;
            pix_q      <= '0;
        end else begin
            clear_done <= clear_wr && (clear_addr == CLEAR_LAST);
            if ((state == S_IDLE) && clear_req) color_q <= clear_color;
            if ((state == S_PEND) && eof)       clear_addr <= '0;
            else if (clear_wr)                  clear_addr <= clear_addr + 1'b1;
            rd_d1   <= vslot;
            disp_d1 <= display;
            disp_d2 <= disp_d1;
            if (rd_d1) pix_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural single-port RAM.
module tb_vga_fb_arbiter;

    logic        pclk = 1'b0;
    logic        rst;
    logic [9:0]  hcount, vcount;
    logic        display, eof;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [7:0]  wr_data;
    logic        clear_req;
    logic [7:0]  clear_color;
    logic        busy, clear_done;
    logic        mem_en, mem_we;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  pix_data;
    logic        pix_valid;

    logic [7:0]  ram [0:32767];

    int vectors = 0;
    int miscompares = 0;

    vga_fb_arbiter dut (
        .pclk(pclk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .display(display), .eof(eof),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .clear_req(clear_req), .clear_color(clear_color),
        .busy(busy), .clear_done(clear_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_data(pix_data), .pix_valid(pix_valid)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        int n_en, n_we, n, bad, rdy_bad, vs_bad, done_at, dones;
        for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
        rst = 1'b1; hcount = 0; vcount = 0; display = 0; eof = 0;
        wr_valid = 0; wr_x = 0; wr_y = 0; wr_data = 0;
        clear_req = 0; clear_color = 0;
        repeat (3) @(posedge pclk);
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_clear_done", 32'(clear_done), 0);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_pix_data", 32'(pix_data), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        rst = 1'b0;
        tick();

        // One full line, no writer: one read per 4 active pixels.
        n_en = 0; n_we = 0;
        vcount = 20;
        for (int h = 0; h < 800; h++) begin
            hcount = 10'(h);
            display = (h < 640);
            #1;
            if (mem_en) n_en++;
            if (mem_we) n_we++;
            tick();
        end
        chk("line_reads", 32'(n_en), 160);
        chk("line_writes", 32'(n_we), 0);

        // Writer transfers in blanking.
        display = 0; hcount = 700; vcount = 10;
        wr_valid = 1; wr_x = 5; wr_y = 3; wr_data = 8'hA5;
        #1;
        chk("wr_ready_blank", 32'(wr_ready), 1);
        chk("wr_en", 32'(mem_en), 1);
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_addr", 32'(mem_addr), 485);
        chk("wr_wdata", 32'(mem_wdata), 32'hA5);
        tick();
        wr_x = 6; wr_y = 3; wr_data = 8'h5A;
        #1;
        chk("wr_addr2", 32'(mem_addr), 486);
        tick();
        wr_x = 159; wr_y = 119; wr_data = 8'h7E;
        #1;
        chk("wr_addr_last", 32'(mem_addr), 19199);
        tick();
        wr_x = 160; wr_y = 0; wr_data = 8'hFF;
        #1;
        chk("oob_x_ready", 32'(wr_ready), 1);
        chk("oob_x_en", 32'(mem_en), 0);
        tick();
        wr_x = 0; wr_y = 120;
        #1;
        chk("oob_y_en", 32'(mem_en), 0);
        tick();
        chk("ram_485", 32'(ram[485]), 32'hA5);
        chk("ram_19199", 32'(ram[19199]), 32'h7E);

        // Active video with writer held valid.
        wr_valid = 1; wr_x = 0; wr_y = 0; wr_data = 8'h11;
        display = 1; vcount = 12; hcount = 20;
        #1;
        chk("vslot_en", 32'(mem_en), 1);
        chk("vslot_we", 32'(mem_we), 0);
        chk("vslot_addr", 32'(mem_addr), 485);
        chk("vslot_ready", 32'(wr_ready), 0);
        tick();
        hcount = 21;
        #1;
        chk("free_ready", 32'(wr_ready), 1);
        chk("free_we", 32'(mem_we), 1);
        chk("free_addr", 32'(mem_addr), 0);
        chk("pix_valid_early", 32'(pix_valid), 0);
        tick();
        hcount = 22;
        #1;
        chk("pix_valid_h22", 32'(pix_valid), 1);
        chk("pix_h22", 32'(pix_data), 32'hA5);
        tick();
        hcount = 23;
        tick();
        hcount = 24;
        #1;
        chk("vslot_addr2", 32'(mem_addr), 486);
        chk("vslot_ready2", 32'(wr_ready), 0);
        tick();
        hcount = 25;
        #1;
        chk("pix_h25", 32'(pix_data), 32'hA5);
        tick();
        hcount = 26;
        #1;
        chk("pix_h26", 32'(pix_data), 32'h5A);
        tick();
        wr_valid = 0; display = 0; hcount = 640;
        tick();
        tick();
        chk("pix_valid_off", 32'(pix_valid), 0);
        chk("pix_data_off", 32'(pix_data), 0);

        // clear_req together with eof in IDLE only arms the clear.
        vcount = 480; hcount = 640;
        clear_req = 1; clear_color = 8'h1C; eof = 1;
        #1;
        chk("busy_before", 32'(busy), 0);
        tick();
        clear_req = 0; eof = 0;
        #1;
        chk("busy_pend", 32'(busy), 1);
        chk("pend_no_write", 32'(mem_en), 0);
        chk("pend_ready", 32'(wr_ready), 1);
        clear_req = 1; clear_color = 8'h99;
        tick();
        clear_req = 0;
        eof = 1;
        #1;
        chk("pend_eof_no_write", 32'(mem_en), 0);
        tick();
        eof = 0;
        wr_valid = 1; wr_x = 10; wr_y = 10; wr_data = 8'h1C;
        n = 0; bad = 0; rdy_bad = 0; done_at = -1;
        for (int c = 0; c < 19300 && done_at < 0; c++) begin
            #1;
            if (clear_done) begin
                done_at = c;
            end else begin
                if (busy && wr_ready) rdy_bad++;
                if (mem_en && mem_we) begin
                    if (mem_addr != 15'(n) || mem_wdata != 8'h1C) bad++;
                    n++;
                end
                tick();
            end
        end
        wr_valid = 0;
        chk("clear_done_at", 32'(done_at), 19200);
        chk("clear_writes", 32'(n), 19200);
        chk("clear_addr_seq", 32'(bad), 0);
        chk("clear_wr_ready", 32'(rdy_bad), 0);
        tick();
        chk("clear_done_pulse", 32'(clear_done), 0);
        chk("busy_after", 32'(busy), 0);
        chk("ram0_clr", 32'(ram[0]), 32'h1C);
        chk("ram485_clr", 32'(ram[485]), 32'h1C);
        chk("ram19199_clr", 32'(ram[19199]), 32'h1C);
        display = 1; vcount = 100; hcount = 400;
        tick();
        tick();
        chk("pix_after_clear", 32'(pix_data), 32'h1C);
        display = 0; hcount = 640; vcount = 480;
        tick();

        // Second clear, interleaved with video slots, reset at address 1000.
        clear_req = 1; clear_color = 8'hE0;
        tick();
        clear_req = 0; eof = 1;
        tick();
        eof = 0;
        n = 0; bad = 0; vs_bad = 0;
        for (int c = 0; c < 2000 && n < 1000; c++) begin
            display = (c < 40);
            vcount = 0;
            hcount = 10'(c);
            #1;
            if (display && (c % 4 == 0) && (mem_we || !mem_en)) vs_bad++;
            if (mem_en && mem_we) begin
                if (mem_addr != 15'(n)) bad++;
                n++;
            end
            tick();
        end
        display = 0; hcount = 640; vcount = 480;
        chk("partial_writes", 32'(n), 1000);
        chk("partial_addr_seq", 32'(bad), 0);
        chk("vslot_no_write", 32'(vs_bad), 0);
        rst = 1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(clear_done), 0);
        chk("midrst_en", 32'(mem_en), 0);
        tick();
        rst = 0;
        dones = 0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (clear_done || busy) dones++;
            tick();
        end
        chk("midrst_quiet", 32'(dones), 0);
        chk("ram999_new", 32'(ram[999]), 32'hE0);
        chk("ram1000_old", 32'(ram[1000]), 32'h1C);
        chk("ram19199_old", 32'(ram[19199]), 32'h1C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Shares one single-port synchronous framebuffer RAM (160x120, 8-bit RGB332) between the VGA pixel fetch and a pixel-writer client, and sequences a full-frame clear. It sits between VGASynchronizer (whose hcount/vcount/display/eof it consumes) and the video DAC. Video fetch always has priority; writes and clears use the remaining memory cycles.

## Interface
Parameters:
- FB_W, 160, framebuffer width in pixels (one fb pixel = 4x4 screen pixels)
- FB_H, 120, framebuffer height
- ADDR_W, 15, RAM address width
- DATA_W, 8, pixel width

Ports (one clock; reset is asynchronous and active-high):
- pclk  in  1  pixel clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- hcount  in  10  from synchronizer
- vcount  in  10  from synchronizer
- display  in  1  from synchronizer, active-area flag
- eof  in  1  from synchronizer, one-cycle end-of-frame strobe
- wr_valid  in  1  writer request
- wr_ready  out  1  writer may transfer this cycle
- wr_x  in  8  writer column
- wr_y  in  7  writer row
- wr_data  in  DATA_W  writer pixel
- clear_req  in  1  request frame clear
- clear_color  in  DATA_W  clear value, sampled with clear_req
- busy  out  1  clear pending or in progress
- clear_done  out  1  one-cycle pulse after last clear write
- mem_en  out  1  RAM access this cycle
- mem_we  out  1  RAM write (valid with mem_en)
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after read
- pix_data  out  DATA_W  pixel to DAC, 0 when pix_valid=0
- pix_valid  out  1  display delayed two cycles

## Operation
- Video slot: vslot = display && hcount[1:0]==0. In a vslot: mem_en=1, mem_we=0, mem_addr = (vcount>>2)*160 + (hcount>>2) (shift-add, y<<7 + y<<5 + x). No other access in a vslot.
- Non-vslot cycles, priority: CLEAR write, then writer, else mem_en=0.
- Writer: wr_ready = !vslot && state!=CLEAR && state!=... (ready in IDLE and PEND only). Transfer when wr_valid && wr_ready: mem_en=1, mem_we=1, addr = wr_y*160+wr_x, wdata=wr_data, same cycle. If wr_x>=160 or wr_y>=120: transfer completes, mem_en=0 (dropped).
- mem_* are combinational from registered state and current inputs.
- FSM states IDLE, PEND, CLEAR:
  - IDLE: clear_req=1 -> PEND, latch clear_color.
  - PEND: eof=1 -> CLEAR, clear_addr<=0.
  - CLEAR: each non-vslot cycle writes latched color to clear_addr, clear_addr++. Write of address 19199 -> IDLE; clear_done=1 next cycle.
  - clear_req ignored outside IDLE.
- busy = (state!=IDLE).

## Timing
- Reset: state IDLE, clear_addr 0, pix_data 0, pix_valid 0, clear_done 0, busy 0; mem_en 0 while display=0 and wr_valid=0.
- Read latency: read issued cycle t, mem_rdata sampled end of t+1, pix_data valid cycle t+2, held 4 cycles. pix_valid(t) = display(t-2). Downstream delays hsync/vsync by 2 cycles.
- Writer handshake: single-cycle; wr_ready may deassert any cycle; wr_valid need not be held for acceptance semantics beyond the transfer cycle.
- Clear starts at eof (hcount=640, vcount=480); 19200 writes fit in vertical blanking (≥36000 cycles), so a clear completes before line 0 of next frame. clear_done is exactly 19200 cycles after PEND->CLEAR when no vslots intervene.
- clear_req and eof same cycle in IDLE: go to PEND only; CLEAR starts on next eof.
- Reset mid-CLEAR: immediate return to IDLE, partial clear left in RAM, no clear_done.

## Test plan
- Reset with pclk running -> all outputs at reset values; release, run one frame with no writes -> mem_we never 1, mem_en=1 exactly 160*480 times.
- Write (x=5,y=3,data=0xA5) during blanking -> mem_we=1, mem_addr=485, mem_wdata=0xA5 same cycle; later frame at screen row 12..15, col 20..23 pix_data=0xA5 two cycles after hcount=20.
- Hold wr_valid=1 during active video -> wr_ready=0 exactly on hcount%4==0 in active area; no write ever coincides with a read.
- Write x=160,y=0 -> wr_ready=1 handshake, mem_en=0.
- clear_req with color 0x1C mid-frame -> busy=1, CLEAR entered on eof, 19200 writes addr 0..19199, clear_done pulse once, next frame all pix_data=0x1C; wr_ready=0 throughout CLEAR.
- Assert rst at clear_addr=1000 -> state IDLE, busy=0, no clear_done; addresses ≥1000 keep old contents.
